// File: rtl/key_reader_pkg.sv
// ============================================================================
// key_reader_pkg : register map and defaults for the key input reader
// Revision 1.0
// ============================================================================
`default_nettype none

package key_reader_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_RSVD = 2'd3;

    // 10 ms of stable level at a 50 MHz system clock
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// key_debounce : one active-low key, 2-flop synchroniser plus stable-level filter
// Revision 1.0
// ============================================================================
`default_nettype none

module key_debounce
    import key_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pressed,
    output logic press_edge
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_out;
    logic             synced_pressed;
    logic             accept;
    logic [CNT_W-1:0] count;

    assign synced_pressed = ~sync_out;

    // The clock that would bring the count to DEBOUNCE_CYCLES is the accept
    // clock, so the counter never holds that value and cannot wrap.
    assign accept     = (synced_pressed != pressed) && (count == CNT_LAST);
    assign press_edge = accept && synced_pressed;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b1;
            sync_out  <= 1'b1;
            count     <= '0;
            pressed   <= 1'b0;
        end else begin
            sync_meta <= key_n;
            sync_out  <= sync_meta;
            if (synced_pressed == pressed) begin
                count <= '0;
            end else if (accept) begin
                pressed <= synced_pressed;
                count   <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/key_input_reader.sv
// ============================================================================
// key_input_reader : debounced push-button port with edge capture and IRQ
// Revision 1.0
// ============================================================================
`default_nettype none

module key_input_reader
    import key_reader_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iChip_select_n,
    input  logic              iRead_n,
    input  logic              iWrite_n,
    input  logic [1:0]        iAddress,
    input  logic [DATA_W-1:0] iData,
    input  logic [WIDTH-1:0]  iKeys,
    output logic [DATA_W-1:0] oData,
    output logic              oIrq
);

    logic [WIDTH-1:0]  key_state;
    logic [WIDTH-1:0]  press_edge;
    logic [WIDTH-1:0]  irq_mask;
    logic [WIDTH-1:0]  edge_cap;
    logic [WIDTH-1:0]  clear_bits;
    logic [DATA_W-1:0] read_word;
    logic              wr_en;
    logic              rd_en;
    logic              unused_data;

    assign unused_data = ^iData;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk       (iClk),
                .rst       (iReset),
                .key_n     (iKeys[i]),
                .pressed   (key_state[i]),
                .press_edge(press_edge[i])
            );
        end
    endgenerate

    assign wr_en = ~iChip_select_n & ~iWrite_n;
    assign rd_en = ~iChip_select_n & ~iRead_n;

    assign clear_bits = (wr_en && (iAddress == ADDR_EDGE)) ? iData[WIDTH-1:0] : '0;

    always_comb begin
        read_word = '0;
        case (iAddress)
            ADDR_DATA: read_word = DATA_W'(key_state);
            ADDR_MASK: read_word = DATA_W'(irq_mask);
            ADDR_EDGE: read_word = DATA_W'(edge_cap);
            ADDR_RSVD: read_word = '0;
            default:   read_word = '0;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            irq_mask <= '0;
            edge_cap <= '0;
            oData    <= '0;
            oIrq     <= 1'b0;
        end else begin
            if (wr_en && (iAddress == ADDR_MASK)) begin
                irq_mask <= iData[WIDTH-1:0];
            end
            // New presses are OR-ed in after the clear, so a press wins a tie
            edge_cap <= (edge_cap & ~clear_bits) | press_edge;
            oData    <= rd_en ? read_word : '0;
            oIrq     <= |(edge_cap & irq_mask);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_key_input_reader.sv
// ============================================================================
// tb_key_input_reader : directed bench for key_input_reader (WIDTH=4, debounce 4)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_key_input_reader;

    localparam int WIDTH = 4;
    localparam int DEB   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n;
    logic        rd_n;
    logic        wr_n;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [WIDTH-1:0] keys;
    logic [31:0] rdata;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        cs_n;
        logic        rd_n;
        logic        wr_n;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [15];

    key_input_reader #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .iClk          (clk),
        .iReset        (rst),
        .iChip_select_n(cs_n),
        .iRead_n       (rd_n),
        .iWrite_n      (wr_n),
        .iAddress      (addr),
        .iData         (wdata),
        .iKeys         (keys),
        .oData         (rdata),
        .oIrq          (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        cs_n = 1'b1;
        rd_n = 1'b1;
        wr_n = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        cs_n  = 1'b0;
        wr_n  = 1'b0;
        rd_n  = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        bus_idle();
    endtask

    task automatic bus_read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        cs_n = 1'b0;
        rd_n = 1'b0;
        wr_n = 1'b1;
        addr = a;
        tick();
        check(name, rdata, exp);
        bus_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // cs_n, rd_n, wr_n, addr, wdata, expected oData, expected oIrq
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,         32'h0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'd1, 32'h0,         32'h0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 2'd2, 32'h0,         32'h0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'd3, 32'h0,         32'h0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'd1, 32'hFFFF_FFF5, 32'h0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'd1, 32'h0,         32'h5, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'hF,         32'h0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,         32'h0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'd3, 32'hF,         32'h0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'd3, 32'h0,         32'h0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 2'd1, 32'h3,         32'h5, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 2'd1, 32'h0,         32'h3, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 2'd1, 32'h0,         32'h0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h0,         32'h0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 2'd1, 32'h0,         32'h0, 1'b0};

        rst   = 1'b1;
        keys  = '1;
        addr  = '0;
        wdata = '0;
        bus_idle();
        repeat (3) tick();
        rst = 1'b0;
        check("reset oData", rdata, 32'h0);
        check("reset oIrq", {31'h0, irq}, 32'h0);

        foreach (vecs[i]) begin
            cs_n  = vecs[i].cs_n;
            rd_n  = vecs[i].rd_n;
            wr_n  = vecs[i].wr_n;
            addr  = vecs[i].addr;
            wdata = vecs[i].wdata;
            tick();
            check($sformatf("vec%0d data", i), rdata, vecs[i].exp_data);
            check($sformatf("vec%0d irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
        end
        bus_idle();

        // Press key0; the stable level flips on the 6th edge, so a read
        // sampled on that edge still sees 0 and the next one sees 1.
        keys = 4'b1110;
        cs_n = 1'b0;
        rd_n = 1'b0;
        addr = 2'd0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("latency edge%0d", k), rdata, (k == 7) ? 32'h1 : 32'h0);
        end
        bus_idle();
        bus_read_check("edge after press", 2'd2, 32'h1);
        check("irq masked", {31'h0, irq}, 32'h0);

        // 3-clock glitch on key1 is rejected
        keys = 4'b1100;
        repeat (3) tick();
        keys = 4'b1110;
        repeat (6) tick();
        bus_read_check("glitch data", 2'd0, 32'h1);
        bus_read_check("glitch edge", 2'd2, 32'h1);
        check("glitch irq", {31'h0, irq}, 32'h0);

        // Clear, enable mask, release key0 (release is not captured)
        bus_write(2'd2, 32'h1);
        bus_read_check("edge cleared", 2'd2, 32'h0);
        bus_write(2'd1, 32'h1);
        keys = 4'b1111;
        repeat (8) tick();
        bus_read_check("release data", 2'd0, 32'h0);
        bus_read_check("release edge", 2'd2, 32'h0);
        check("release irq", {31'h0, irq}, 32'h0);

        // Re-press key0: edge sets on edge 6, oIrq follows on edge 7
        keys = 4'b1110;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("irq edge%0d", k), {31'h0, irq}, (k == 7) ? 32'h1 : 32'h0);
        end
        cs_n  = 1'b0;
        wr_n  = 1'b0;
        addr  = 2'd2;
        wdata = 32'h1;
        tick();
        bus_idle();
        check("irq on clear clock", {31'h0, irq}, 32'h1);
        tick();
        check("irq after clear", {31'h0, irq}, 32'h0);
        bus_read_check("edge after w1c", 2'd2, 32'h0);

        // key2 press edge coincides with a W1C of bit 2
        keys = 4'b1010;
        repeat (5) tick();
        cs_n  = 1'b0;
        wr_n  = 1'b0;
        addr  = 2'd2;
        wdata = 32'h4;
        tick();
        bus_idle();
        bus_read_check("set wins", 2'd2, 32'h4);
        check("set wins irq", {31'h0, irq}, 32'h0);

        // Read of EDGE on the clock key1's edge sets returns the old value
        keys = 4'b1000;
        repeat (5) tick();
        cs_n = 1'b0;
        rd_n = 1'b0;
        addr = 2'd2;
        tick();
        check("read old edge", rdata, 32'h4);
        tick();
        check("edge retained", rdata, 32'h6);
        bus_idle();

        // Reset in the middle of key3's debounce count
        keys = 4'b0111;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post-reset oData", rdata, 32'h0);
        check("post-reset oIrq", {31'h0, irq}, 32'h0);
        cs_n = 1'b0;
        rd_n = 1'b0;
        addr = 2'd0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("reaccept edge%0d", k), rdata, (k == 7) ? 32'h8 : 32'h0);
        end
        bus_idle();
        bus_read_check("reaccept edge cap", 2'd2, 32'h8);
        bus_read_check("mask after reset", 2'd1, 32'h0);
        check("irq after reset", {31'h0, irq}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
